// File: rtl/display_update_ctrl.sv
// Sequencer between the clock core and the MAX7219 output stage: startup and periodic config writes,
// change/force-driven digit updates, stable snapshot during transfers. Optional ack watchdog: DISPLAY_UPDATE_WATCHDOG_EN.
module display_update_ctrl #(
    parameter int STARTUP_CYCLES = 16,
    parameter int CONFIG_PERIOD  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    input  logic [5:0] i_seconds,
    input  logic [5:0] i_dp,
    input  logic       i_force,
    output logic       o_stb,
    output logic       o_write_config,
    input  logic       i_busy,
    input  logic       i_ack,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [5:0] o_dp,
    output logic       o_ready
);

    localparam logic [2:0] ST_STARTUP   = 3'd0;
    localparam logic [2:0] ST_CFG_REQ   = 3'd1;
    localparam logic [2:0] ST_CFG_WAIT  = 3'd2;
    localparam logic [2:0] ST_DATA_REQ  = 3'd3;
    localparam logic [2:0] ST_DATA_WAIT = 3'd4;
    localparam logic [2:0] ST_IDLE      = 3'd5;

    localparam logic [7:0] STARTUP_LAST = 8'(STARTUP_CYCLES - 1);
    localparam logic [7:0] PERIOD_LAST  = 8'(CONFIG_PERIOD - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  startup_cnt_q, startup_cnt_d;
    logic [7:0]  upd_cnt_q, upd_cnt_d;
    logic        force_pend_q, force_pend_d;
    logic        stb_q, stb_d;
    logic        wcfg_q, wcfg_d;
    logic [22:0] snap_q, snap_d;
    logic [22:0] live;

    assign live = {i_hours, i_minutes, i_seconds, i_dp};

`ifdef DISPLAY_UPDATE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            in_wait;

    assign in_wait = (state_q == ST_CFG_WAIT) || (state_q == ST_DATA_WAIT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        startup_cnt_d = startup_cnt_q;
        upd_cnt_d     = upd_cnt_q;
        // A force outside IDLE is remembered; in IDLE it acts directly.
        force_pend_d  = force_pend_q | (i_force && (state_q != ST_IDLE));
        stb_d         = 1'b0;
        wcfg_d        = 1'b0;
        snap_d        = snap_q;
        case (state_q)
            ST_STARTUP: begin
                if (startup_cnt_q >= STARTUP_LAST) state_d = ST_CFG_REQ;
                else                               startup_cnt_d = startup_cnt_q + 8'd1;
            end
            ST_CFG_REQ: begin
                if (!i_busy) begin
                    stb_d   = 1'b1;
                    wcfg_d  = 1'b1;
                    state_d = ST_CFG_WAIT;
                end
            end
            ST_CFG_WAIT: begin
                if (i_ack) state_d = ST_DATA_REQ;
            end
            ST_DATA_REQ: begin
                if (!i_busy) begin
                    stb_d   = 1'b1;
                    snap_d  = live;
                    state_d = ST_DATA_WAIT;
                end
            end
            ST_DATA_WAIT: begin
                if (i_ack) begin
                    if (upd_cnt_q >= PERIOD_LAST) begin
                        upd_cnt_d = 8'd0;
                        state_d   = ST_CFG_REQ;
                    end else begin
                        upd_cnt_d = upd_cnt_q + 8'd1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if ((live != snap_q) || force_pend_q || i_force) begin
                    force_pend_d = 1'b0;
                    state_d      = ST_DATA_REQ;
                end
            end
            default: state_d = ST_STARTUP;
        endcase

`ifdef DISPLAY_UPDATE_WATCHDOG_EN
        // Counter is held at zero outside the WAIT states, so it restarts on every entry.
        wd_cnt_d = in_wait ? wd_cnt_q + WD_W'(1) : '0;
        if (in_wait && !i_ack && (wd_cnt_q >= WD_LAST)) begin
            wd_cnt_d     = '0;
            upd_cnt_d    = 8'd0;
            force_pend_d = 1'b1;
            state_d      = ST_CFG_REQ;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= ST_STARTUP;
            startup_cnt_q <= 8'd0;
            upd_cnt_q     <= 8'd0;
            force_pend_q  <= 1'b0;
            stb_q         <= 1'b0;
            wcfg_q        <= 1'b0;
            snap_q        <= '0;
`ifdef DISPLAY_UPDATE_WATCHDOG_EN
            wd_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            startup_cnt_q <= startup_cnt_d;
            upd_cnt_q     <= upd_cnt_d;
            force_pend_q  <= force_pend_d;
            stb_q         <= stb_d;
            wcfg_q        <= wcfg_d;
            snap_q        <= snap_d;
`ifdef DISPLAY_UPDATE_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
`endif
        end
    end

    assign o_stb          = stb_q;
    assign o_write_config = wcfg_q;
    assign {o_hours, o_minutes, o_seconds, o_dp} = snap_q;
    assign o_ready        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_display_update_ctrl.sv
// Bench for display_update_ctrl: directed table of IDLE stimuli, multi-cycle corner sequences,
// and a randomized run checked against a transaction-level model of strobes, snapshots and acks.
module tb_display_update_ctrl;

    localparam int STARTUP_CYCLES = 16;
    localparam int CONFIG_PERIOD  = 8;
    localparam int TIMEOUT_CYCLES = 1024;

    typedef logic [22:0] snap_t;

    typedef struct {
        snap_t live;
        bit    frc;
        bit    exp_stb;
        int    exp_cfg;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [4:0] i_hours = '0;
    logic [5:0] i_minutes = '0;
    logic [5:0] i_seconds = '0;
    logic [5:0] i_dp = '0;
    logic       i_force = 1'b0;
    logic       i_busy = 1'b0;
    logic       i_ack = 1'b0;
    logic       o_stb, o_write_config, o_ready;
    logic [4:0] o_hours;
    logic [5:0] o_minutes, o_seconds, o_dp;
    snap_t      out_snap;

    always #5 i_clk = ~i_clk;

    display_update_ctrl #(
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .CONFIG_PERIOD (CONFIG_PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_hours       (i_hours),
        .i_minutes     (i_minutes),
        .i_seconds     (i_seconds),
        .i_dp          (i_dp),
        .i_force       (i_force),
        .o_stb         (o_stb),
        .o_write_config(o_write_config),
        .i_busy        (i_busy),
        .i_ack         (i_ack),
        .o_hours       (o_hours),
        .o_minutes     (o_minutes),
        .o_seconds     (o_seconds),
        .o_dp          (o_dp),
        .o_ready       (o_ready)
    );

    assign out_snap = {o_hours, o_minutes, o_seconds, o_dp};

    // scoreboard / reference model state
    int    n_vec = 0;
    int    n_err = 0;
    int    n_cfg = 0;
    int    n_data = 0;
    bit    exp_cfg_next = 1'b1;
    int    data_cnt = 0;
    bit    in_flight = 1'b0;
    bit    fl_cfg = 1'b0;
    logic  prev_stb = 1'b0;
    snap_t exp_q[$];
    int    ack_cnt = 0;
    int    ack_lat = 20;
    bit    ack_en = 1'b1;
    vec_t  tbl[8];

    function automatic snap_t mk(input int h, input int m, input int s, input int dp);
        logic [4:0] hh;
        logic [5:0] mm, ss, dd;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        dd = dp[5:0];
        return {hh, mm, ss, dd};
    endfunction

    function automatic snap_t live_v();
        return {i_hours, i_minutes, i_seconds, i_dp};
    endfunction

    task automatic set_live(input snap_t v);
        {i_hours, i_minutes, i_seconds, i_dp} = v;
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: capture what the DUT sees at the edge, observe outputs after it, update model, drive ack.
    task automatic step();
        logic  a_rst, a_busy, a_ack;
        snap_t a_live;
        a_rst  = i_reset_n;
        a_busy = i_busy;
        a_ack  = i_ack;
        a_live = live_v();
        @(posedge i_clk);
        #1;
        if (!a_rst) begin
            exp_cfg_next = 1'b1;
            data_cnt     = 0;
            in_flight    = 1'b0;
            exp_q.delete();
            ack_cnt      = 0;
            prev_stb     = 1'b0;
            chk_eq("rst_stb", o_stb, 0);
            chk_eq("rst_wcfg", o_write_config, 0);
            chk_eq("rst_ready", o_ready, 0);
            chk_eq("rst_snap", out_snap, 0);
        end else begin
            if (a_ack && in_flight) begin
                in_flight = 1'b0;
                if (fl_cfg) begin
                    exp_cfg_next = 1'b0;
                end else begin
                    data_cnt++;
                    chk_eq("snap_at_ack", out_snap, exp_q.pop_front());
                    if (data_cnt == CONFIG_PERIOD) begin
                        data_cnt     = 0;
                        exp_cfg_next = 1'b1;
                    end
                    chk_eq("ready_after_ack", o_ready, (data_cnt != 0));
                end
            end
            if (o_stb) begin
                chk_eq("stb_back_to_back", prev_stb, 0);
                chk_eq("stb_while_busy", a_busy, 0);
`ifdef DISPLAY_UPDATE_WATCHDOG_EN
                if (in_flight) begin
                    exp_cfg_next = 1'b1;
                    data_cnt     = 0;
                    exp_q.delete();
                end
`else
                chk_eq("stb_while_waiting", in_flight, 0);
`endif
                chk_eq("stb_kind", o_write_config, exp_cfg_next);
                if (o_write_config) begin
                    n_cfg++;
                end else begin
                    n_data++;
                    chk_eq("snap_latch", out_snap, a_live);
                    exp_q.push_back(a_live);
                end
                in_flight = 1'b1;
                fl_cfg    = o_write_config;
                ack_cnt   = ack_lat;
            end else if (in_flight) begin
                chk_eq("ready_in_flight", o_ready, 0);
                if (!fl_cfg && exp_q.size() > 0) chk_eq("snap_hold", out_snap, exp_q[0]);
            end
            prev_stb = o_stb;
        end
        i_ack = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0 && ack_en) i_ack = 1'b1;
        end
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        while (!o_ready && n < bound) begin
            step();
            n++;
        end
        chk_eq("ready_wait", o_ready, 1);
    endtask

    task automatic wait_stb(input int bound);
        int n;
        n = 0;
        while (!o_stb && n < bound) begin
            step();
            n++;
        end
        chk_eq("stb_wait", o_stb, 1);
    endtask

    task automatic startup_seq();
        int n;
        i_reset_n = 1'b0;
        i_busy    = 1'b0;
        i_force   = 1'b0;
        set_live(mk(12, 34, 56, 0));
        step();
        step();
        i_reset_n = 1'b1;
        n = 0;
        while (!o_stb && n < 40) begin
            step();
            n++;
        end
        chk_eq("startup_latency", n, STARTUP_CYCLES + 1);
        chk_eq("startup_kind", o_write_config, 1);
        wait_ready(100);
        chk_eq("first_snap", out_snap, mk(12, 34, 56, 0));
    endtask

    initial begin
        int    c0;
        int    n;
        tbl[0] = '{mk(12, 34, 58, 0),  1'b0, 1'b0, 0};
        tbl[1] = '{mk(12, 34, 59, 0),  1'b0, 1'b1, 0};
        tbl[2] = '{mk(12, 35, 59, 0),  1'b0, 1'b1, 0};
        tbl[3] = '{mk(13, 35, 59, 0),  1'b0, 1'b1, 0};
        tbl[4] = '{mk(13, 35, 59, 15), 1'b0, 1'b1, 0};
        tbl[5] = '{mk(13, 35, 59, 15), 1'b1, 1'b1, 1};
        tbl[6] = '{mk(13, 36, 0, 15),  1'b1, 1'b1, 0};
        tbl[7] = '{mk(13, 36, 0, 15),  1'b0, 1'b0, 0};

        ack_lat = 20;
        ack_en  = 1'b1;
        startup_seq();

        // change in IDLE: two-cycle latency, snapshot frozen while the input moves on
        i_seconds = 6'd57;
        step();
        chk_eq("lat_cycle1", o_stb, 0);
        step();
        chk_eq("lat_cycle2", o_stb, 1);
        chk_eq("lat_kind", o_write_config, 0);
        chk_eq("snap_57", o_seconds, 57);
        i_seconds = 6'd58;
        wait_ready(100);
        chk_eq("hold_57", o_seconds, 57);
        wait_stb(10);
        chk_eq("snap_58", o_seconds, 58);
        wait_ready(100);

        for (int r = 0; r < 8; r++) begin
            wait_ready(200);
            c0 = n_cfg;
            set_live(tbl[r].live);
            i_force = tbl[r].frc;
            step();
            i_force = 1'b0;
            chk_eq("tbl_cycle1", o_stb, 0);
            step();
            chk_eq("tbl_stb", o_stb, tbl[r].exp_stb);
            if (tbl[r].exp_stb) begin
                chk_eq("tbl_kind", o_write_config, 0);
                chk_eq("tbl_snap", out_snap, tbl[r].live);
            end else begin
                repeat (5) begin
                    step();
                    chk_eq("tbl_quiet", o_stb, 0);
                end
            end
            wait_ready(200);
            chk_eq("tbl_cfg_count", n_cfg - c0, tbl[r].exp_cfg);
        end

        // force during DATA_WAIT yields exactly one extra update
        set_live(mk(13, 36, 1, 15));
        wait_stb(5);
        c0 = n_data;
        step();
        i_force = 1'b1;
        step();
        i_force = 1'b0;
        wait_ready(100);
        wait_stb(5);
        chk_eq("force_kind", o_write_config, 0);
        wait_ready(100);
        repeat (30) step();
        chk_eq("force_once", n_data - c0, 1);

        // busy held in DATA_REQ, then reset in the middle of DATA_WAIT
        i_busy = 1'b1;
        set_live(mk(13, 36, 2, 15));
        step();
        repeat (50) begin
            step();
            chk_eq("busy_hold", o_stb, 0);
        end
        i_busy = 1'b0;
        step();
        chk_eq("busy_release", o_stb, 1);
        chk_eq("busy_snap", o_seconds, 2);
        repeat (5) step();
        startup_seq();

        // ack never arrives
        ack_en = 1'b0;
        i_seconds = 6'd3;
        wait_stb(5);
`ifdef DISPLAY_UPDATE_WATCHDOG_EN
        c0 = n_cfg;
        n = 0;
        while (n_cfg == c0 && n < 1100) begin
            step();
            n++;
        end
        ack_en = 1'b1;
        chk_eq("wd_cycles", n, TIMEOUT_CYCLES + 1);
        chk_eq("wd_kind", o_write_config, 1);
        wait_ready(300);
        chk_eq("wd_snap", out_snap, live_v());
`else
        c0 = n_cfg + n_data;
        repeat (1100) step();
        chk_eq("no_wd_stb", n_cfg + n_data - c0, 0);
        chk_eq("no_wd_ready", o_ready, 0);
        ack_en = 1'b1;
`endif
        startup_seq();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) i_seconds = 6'($urandom_range(0, 59));
            if ($urandom_range(0, 99) == 0) i_minutes = 6'($urandom_range(0, 59));
            if ($urandom_range(0, 299) == 0) i_hours = 5'($urandom_range(0, 23));
            if ($urandom_range(0, 149) == 0) i_dp = 6'($urandom_range(0, 63));
            i_force = ($urandom_range(0, 24) == 0);
            i_busy  = ($urandom_range(0, 9) < 3);
            ack_lat = $urandom_range(1, 10);
            step();
        end
        i_force = 1'b0;
        i_busy  = 1'b0;
        repeat (60) step();
        wait_ready(200);
        chk_eq("final_snap", out_snap, live_v());
        c0 = n_data + n_cfg;
        repeat (10) step();
        chk_eq("final_quiet", n_data + n_cfg - c0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
